operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter CNT_W, default 2: width of each per-register pending-write counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  decoded instruction present.
REQ-005 SHALL have port in_ready  output  1  instruction accepted this cycle when high with in_valid.
REQ-006 SHALL have ports in_rs1, in_rs2, in_rd  input  5 each  source and destination register indices.
REQ-007 SHALL have ports in_use1, in_use2  input  1 each  instruction reads rs1 / rs2.
REQ-008 SHALL have port in_regwrite  input  1  instruction will write in_rd.
REQ-009 SHALL have ports rf_rs1, rf_rs2  output  5 each  register file read addresses.
REQ-010 SHALL have ports rf_readdata1, rf_readdata2  input  32 each  combinational register file read data.
REQ-011 SHALL have ports wb_valid (1), wb_rd (5), wb_data (32)  input  writeback request.
REQ-012 SHALL have ports rf_regwrite (1), rf_rd (5), rf_writedata (32)  output  register file write port.
REQ-013 SHALL have ports out_valid (1) output, out_ready (1) input  downstream handshake.
REQ-014 SHALL have ports out_op1, out_op2 (32 each), out_rd (5), out_regwrite (1)  output  registered operands and destination.

Function
REQ-015 SHALL drive rf_rs1 = in_rs1, rf_rs2 = in_rs2 combinationally.
REQ-016 SHALL drive rf_regwrite = wb_valid && (wb_rd != 0), rf_rd = wb_rd, rf_writedata = wb_data combinationally.
REQ-017 SHALL keep a scoreboard counter cnt[r] of CNT_W bits for r = 1..31; cnt[0] is constant 0.
REQ-018 SHALL define wb_hit(r) = wb_valid && wb_rd == r && r != 0.
REQ-019 SHALL flag source hazard for rsN when in_useN && rsN != 0 && cnt[rsN] != 0 && !(cnt[rsN] == 1 && wb_hit(rsN)).
REQ-020 SHALL flag destination hazard when in_regwrite && in_rd != 0 && cnt[in_rd] == all-ones && !wb_hit(in_rd).
REQ-021 SHALL drive in_ready = !hazard && (!out_valid || out_ready); in_ready may depend combinationally on in_* fields and wb_*.
REQ-022 SHALL define fire = in_valid && in_ready.
REQ-023 SHALL select operand N: 0 if !in_useN or rsN == 0; else wb_data if wb_hit(rsN); else rf_readdataN.
REQ-024 On fire SHALL register operands into out_op1/out_op2, in_rd into out_rd, (in_regwrite && in_rd != 0) into out_regwrite, and set out_valid, all visible the next cycle (latency 1).
REQ-025 Without fire, SHALL clear out_valid when out_valid && out_ready, else hold all out_* stable.
REQ-026 SHALL increment cnt[in_rd] on fire && in_regwrite && in_rd != 0.
REQ-027 SHALL decrement cnt[wb_rd] on wb_valid && wb_rd != 0 && cnt[wb_rd] != 0; writeback to a zero counter SHALL leave it at 0.
REQ-028 Simultaneous increment and decrement of the same counter SHALL leave it unchanged.
REQ-029 Writes to register 0 SHALL never alter the scoreboard nor assert rf_regwrite.
REQ-030 Back-to-back fire with out_ready high SHALL sustain one instruction per cycle.

Reset
REQ-031 While reset is high, SHALL asynchronously force all cnt to 0, out_valid 0, out_op1/out_op2 0, out_rd 0, out_regwrite 0.
REQ-032 Reset mid-operation SHALL discard any held output and all pending entries; in_ready after reset SHALL follow REQ-021 with empty scoreboard.

Verification
REQ-033 Issue rd=5 writer, then reader rs1=5 with no wb -> in_ready=0; wb_valid, wb_rd=5, wb_data=0xDEADBEEF same cycle -> fire, out_op1=0xDEADBEEF next cycle, cnt[5]=0.
REQ-034 Reader rs1=0, rs2=0, in_use1/2=1, rf_readdata=0xFFFFFFFF -> out_op1=out_op2=0, no stall.
REQ-035 Three writers to rd=7 with CNT_W=2, no wb -> first three accepted, fourth in_ready=0 until wb_rd=7.
REQ-036 out_ready held 0 with out_valid=1 -> in_ready=0, out_* stable for 4 cycles; out_ready=1 -> next instruction fires.
REQ-037 wb_valid, wb_rd=9 with cnt[9]=0 -> cnt[9] stays 0, rf_regwrite=1, rf_rd=9.
REQ-038 Assert reset with out_valid=1 and cnt[3]=2 -> out_valid=0, cnt[3]=0 immediately; reader rs1=3 fires first cycle after release.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboard-based hazard stall, writeback bypass of source
// operands, and a single registered output slot with valid/ready handshake.
module operand_fetch #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        in_use1,
  input  logic        in_use2,
  input  logic        in_regwrite,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  input  logic [31:0] rf_readdata1,
  input  logic [31:0] rf_readdata2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        rf_regwrite,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_writedata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [4:0]  out_rd,
  output logic        out_regwrite
);

  localparam int unsigned NREG = 32;

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;
  logic             wb_hit1, wb_hit2, wb_hitd;
  logic             haz1, haz2, hazd, hazard, fire;
  logic [31:0]      op1, op2;

  assign rf_rs1       = in_rs1;
  assign rf_rs2       = in_rs2;
  assign rf_regwrite  = wb_valid && (wb_rd != 5'd0);
  assign rf_rd        = wb_rd;
  assign rf_writedata = wb_data;

  assign wb_hit1 = wb_valid && (wb_rd == in_rs1) && (in_rs1 != 5'd0);
  assign wb_hit2 = wb_valid && (wb_rd == in_rs2) && (in_rs2 != 5'd0);
  assign wb_hitd = wb_valid && (wb_rd == in_rd)  && (in_rd  != 5'd0);

  // A source is safe once its last pending write is retiring this very cycle.
  assign haz1 = in_use1 && (in_rs1 != 5'd0) && (cnt[in_rs1] != '0)
                && !((cnt[in_rs1] == CNT_W'(1)) && wb_hit1);
  assign haz2 = in_use2 && (in_rs2 != 5'd0) && (cnt[in_rs2] != '0)
                && !((cnt[in_rs2] == CNT_W'(1)) && wb_hit2);
  // Saturated counter would overflow on another issue unless one retires now.
  assign hazd = in_regwrite && (in_rd != 5'd0) && (cnt[in_rd] == '1) && !wb_hitd;

  assign hazard   = haz1 || haz2 || hazd;
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;

  always_comb begin
    op1 = 32'd0;
    op2 = 32'd0;
    if (in_use1 && (in_rs1 != 5'd0)) op1 = wb_hit1 ? wb_data : rf_readdata1;
    if (in_use2 && (in_rs2 != 5'd0)) op2 = wb_hit2 ? wb_data : rf_readdata2;
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (fire && in_regwrite && (in_rd != 5'd0)) inc_vec[in_rd] = 1'b1;
    if (wb_valid && (wb_rd != 5'd0) && (cnt[wb_rd] != '0)) dec_vec[wb_rd] = 1'b1;
  end

  // Scoreboard; entry 0 is never updated and stays at its reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r])      cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec_vec[r] && !inc_vec[r]) cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_op1      <= 32'd0;
      out_op2      <= 32'd0;
      out_rd       <= 5'd0;
      out_regwrite <= 1'b0;
    end else if (fire) begin
      out_valid    <= 1'b1;
      out_op1      <= op1;
      out_op2      <= op2;
      out_rd       <= in_rd;
      out_regwrite <= in_regwrite && (in_rd != 5'd0);
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus random traffic, checked against
// a pending-write-count reference model.
module tb_operand_fetch;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_use1, in_use2, in_regwrite;
  logic [4:0]  in_rs1, in_rs2, in_rd, rf_rs1, rf_rs2, wb_rd, rf_rd, out_rd;
  logic [31:0] rf_readdata1, rf_readdata2, wb_data, rf_writedata, out_op1, out_op2;
  logic        wb_valid, rf_regwrite, out_valid, out_ready, out_regwrite;

  int nvec = 0;
  int nerr = 0;

  // Reference model: number of outstanding writes per register plus the output slot.
  int          mcnt [32];
  logic        mov;
  logic [31:0] mop1, mop2;
  logic [4:0]  mrd;
  logic        mrw;
  logic        last_fire;

  operand_fetch #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_use1(in_use1),
    .in_use2(in_use2), .in_regwrite(in_regwrite), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_readdata1(rf_readdata1), .rf_readdata2(rf_readdata2), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .rf_regwrite(rf_regwrite), .rf_rd(rf_rd),
    .rf_writedata(rf_writedata), .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_regwrite(out_regwrite)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    mov = 1'b0; mop1 = '0; mop2 = '0; mrd = '0; mrw = 1'b0;
  endfunction

  // Writes still outstanding on r once this cycle's writeback (if any) retires.
  function automatic int after_wb(input logic [4:0] r);
    if (r == 5'd0) return 0;
    if (wb_valid && wb_rd == r && mcnt[r] > 0) return mcnt[r] - 1;
    return mcnt[r];
  endfunction

  function automatic logic [31:0] pick(input logic use_, input logic [4:0] r,
                                        input logic [31:0] rfd);
    if (!use_ || r == 5'd0) return 32'd0;
    if (wb_valid && wb_rd == r) return wb_data;
    return rfd;
  endfunction

  function automatic void clear_inputs();
    in_valid = 0; in_use1 = 0; in_use2 = 0; in_regwrite = 0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
    rf_readdata1 = 32'h1111_1111; rf_readdata2 = 32'h2222_2222; out_ready = 1;
  endfunction

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic tick();
    logic erdy, fire, dec;
    logic [31:0] o1, o2;
    #2;
    erdy = !((in_use1 && after_wb(in_rs1) > 0) || (in_use2 && after_wb(in_rs2) > 0) ||
             (in_regwrite && in_rd != 0 && after_wb(in_rd) >= MAXC)) && (!mov || out_ready);
    nvec++; if (in_ready !== erdy) begin nerr++;
      $display("FAIL in_ready: got %b exp %b t=%0t", in_ready, erdy, $time); end
    nvec++; if (rf_rs1 !== in_rs1 || rf_rs2 !== in_rs2) begin nerr++;
      $display("FAIL rf_addr: got %0d/%0d exp %0d/%0d", rf_rs1, rf_rs2, in_rs1, in_rs2); end
    nvec++; if (rf_regwrite !== (wb_valid && wb_rd != 0) || rf_rd !== wb_rd ||
                rf_writedata !== wb_data) begin nerr++;
      $display("FAIL rf_write: got %b %0d %h exp %b %0d %h", rf_regwrite, rf_rd,
               rf_writedata, wb_valid && wb_rd != 0, wb_rd, wb_data); end
    o1 = pick(in_use1, in_rs1, rf_readdata1);
    o2 = pick(in_use2, in_rs2, rf_readdata2);
    fire = in_valid && erdy;
    last_fire = fire;
    @(posedge clk);
    dec = wb_valid && wb_rd != 0 && mcnt[wb_rd] > 0;
    if (dec) mcnt[wb_rd]--;
    if (fire && in_regwrite && in_rd != 0) mcnt[in_rd]++;
    if (fire) begin
      mov = 1; mop1 = o1; mop2 = o2; mrd = in_rd; mrw = in_regwrite && in_rd != 0;
    end else if (mov && out_ready) mov = 0;
    #1;
    nvec++; if (out_valid !== mov) begin nerr++;
      $display("FAIL out_valid: got %b exp %b t=%0t", out_valid, mov, $time); end
    nvec++; if (out_op1 !== mop1 || out_op2 !== mop2) begin nerr++;
      $display("FAIL out_ops: got %h/%h exp %h/%h t=%0t", out_op1, out_op2, mop1, mop2, $time); end
    nvec++; if (out_rd !== mrd || out_regwrite !== mrw) begin nerr++;
      $display("FAIL out_dest: got %0d/%b exp %0d/%b", out_rd, out_regwrite, mrd, mrw); end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; model_reset();
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (out_valid !== 0 || out_op1 !== 0 || out_op2 !== 0 || out_rd !== 0 ||
                out_regwrite !== 0) begin nerr++;
      $display("FAIL reset_out: got v=%b op1=%h op2=%h rd=%0d rw=%b exp all 0",
               out_valid, out_op1, out_op2, out_rd, out_regwrite); end
    nvec++; if (in_ready !== 1'b1) begin nerr++;
      $display("FAIL reset_ready: got %b exp 1", in_ready); end
    reset = 0;
  endtask

  task automatic test_raw_bypass();
    clear_inputs();
    in_valid = 1; in_regwrite = 1; in_rd = 5; tick();
    in_regwrite = 0; in_rd = 1; in_use1 = 1; in_rs1 = 5; tick();
    nvec++; if (last_fire !== 1'b0) begin nerr++;
      $display("FAIL raw_stall: fired %b exp 0", last_fire); end
    wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; tick();
    nvec++; if (out_op1 !== 32'hDEADBEEF || out_valid !== 1'b1) begin nerr++;
      $display("FAIL raw_bypass: got %h v=%b exp deadbeef v=1", out_op1, out_valid); end
    clear_inputs(); in_valid = 1; in_use1 = 1; in_rs1 = 5; tick();
    nvec++; if (last_fire !== 1'b1) begin nerr++;
      $display("FAIL raw_cleared: fired %b exp 1", last_fire); end
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    in_valid = 1; in_use1 = 1; in_use2 = 1;
    rf_readdata1 = 32'hFFFFFFFF; rf_readdata2 = 32'hFFFFFFFF; tick();
    nvec++; if (last_fire !== 1'b1 || out_op1 !== 0 || out_op2 !== 0) begin nerr++;
      $display("FAIL zero_reg: fired %b ops %h/%h exp 1 0/0", last_fire, out_op1, out_op2); end
  endtask

  task automatic test_waw_saturate();
    clear_inputs();
    in_valid = 1; in_regwrite = 1; in_rd = 7;
    repeat (3) tick();
    tick();
    nvec++; if (last_fire !== 1'b0) begin nerr++;
      $display("FAIL waw_full: fired %b exp 0", last_fire); end
    tick();
    wb_valid = 1; wb_rd = 7; wb_data = 32'h77; tick();
    nvec++; if (last_fire !== 1'b1) begin nerr++;
      $display("FAIL waw_release: fired %b exp 1", last_fire); end
    in_valid = 0; repeat (3) tick();
    wb_valid = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    clear_inputs();
    in_valid = 1; in_use1 = 1; in_rs1 = 12; rf_readdata1 = 32'hCAFE0001; tick();
    held = out_op1;
    out_ready = 0; rf_readdata1 = 32'hCAFE0002;
    repeat (4) tick();
    nvec++; if (out_op1 !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin nerr++;
      $display("FAIL backpressure: op1 %h v=%b rdy=%b exp %h 1 0", out_op1, out_valid,
               in_ready, held); end
    out_ready = 1; tick();
    nvec++; if (out_op1 !== 32'hCAFE0002) begin nerr++;
      $display("FAIL bp_resume: got %h exp cafe0002", out_op1); end
  endtask

  task automatic test_wb_idle_reg();
    clear_inputs();
    wb_valid = 1; wb_rd = 9; wb_data = 32'h99; tick();
    nvec++; if (rf_regwrite !== 1'b1 || rf_rd !== 5'd9) begin nerr++;
      $display("FAIL wb_idle: rw %b rd %0d exp 1 9", rf_regwrite, rf_rd); end
    wb_valid = 0; in_valid = 1; in_use1 = 1; in_rs1 = 9; tick();
    nvec++; if (last_fire !== 1'b1) begin nerr++;
      $display("FAIL wb_idle_cnt: fired %b exp 1", last_fire); end
    wb_valid = 1; wb_rd = 0; in_valid = 0; tick();
    nvec++; if (rf_regwrite !== 1'b0) begin nerr++;
      $display("FAIL wb_r0: rf_regwrite %b exp 0", rf_regwrite); end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    in_valid = 1; in_regwrite = 1; in_rd = 3; tick(); tick();
    out_ready = 0; in_valid = 0; tick();
    in_valid = 1; in_regwrite = 0; in_use1 = 1; in_rs1 = 3;
    #2 reset = 1; #1;
    nvec++; if (out_valid !== 0 || out_op1 !== 0 || out_rd !== 0 || in_ready !== 1) begin
      nerr++;
      $display("FAIL reset_mid: v=%b op1=%h rd=%0d rdy=%b exp 0 0 0 1", out_valid, out_op1,
               out_rd, in_ready); end
    model_reset();
    @(posedge clk); #1 reset = 0; out_ready = 1;
    tick();
    nvec++; if (last_fire !== 1'b1 || out_valid !== 1'b1) begin nerr++;
      $display("FAIL reset_mid_fire: fired %b v=%b exp 1 1", last_fire, out_valid); end
  endtask

  task automatic test_back_to_back();
    int fired = 0;
    clear_inputs();
    in_valid = 1; in_regwrite = 1; in_use1 = 1;
    for (int i = 0; i < 8; i++) begin
      in_rd = 5'(16 + i); in_rs1 = 5'(8 + i); rf_readdata1 = $urandom;
      tick();
      if (last_fire) fired++;
    end
    nvec++; if (fired != 8) begin nerr++;
      $display("FAIL back_to_back: fired %0d of 8", fired); end
    clear_inputs(); in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      wb_valid = 1; wb_rd = 5'(16 + i); tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom);   in_use1 = 1'($urandom); in_use2 = 1'($urandom);
      in_regwrite = 1'($urandom);
      in_rs1 = 5'($urandom_range(0, 6)); in_rs2 = 5'($urandom_range(0, 6));
      in_rd  = 5'($urandom_range(0, 6));
      rf_readdata1 = $urandom; rf_readdata2 = $urandom;
      wb_valid = ($urandom_range(0, 2) != 0); wb_rd = 5'($urandom_range(0, 6));
      wb_data = $urandom; out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
  endtask

  initial begin
    last_fire = 0;
    test_reset();
    test_raw_bypass();
    test_zero_reg();
    test_waw_saturate();
    test_backpressure();
    test_wb_idle_reg();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
